mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 27 ++
 rtl/mem_stage_branch.sv | 33 +++
 rtl/mem_stage.sv | 149 ++++++++++++++
 tb/tb_mem_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: branch condition codes, flag bit
// positions and the access FSM state encoding.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        BNEQ    = 3'd0,
        BEQ     = 3'd1,
        BGT     = 3'd2,
        BLT     = 3'd3,
        BGTE    = 3'd4,
        BLTE    = 3'd5,
        BOVFL   = 3'd6,
        BUNCOND = 3'd7
    } branchOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memState_e;

    // flags bus is packed as {N, Z, V}
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/mem_stage_branch.sv
// Combinational branch condition evaluation from the {N,Z,V} flags.
module branch_resolve
    import mem_stage_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] branch_op,
    output logic       cond
);

    logic flagN;
    logic flagZ;
    logic flagV;

    assign flagN = flags[FLAG_N];
    assign flagZ = flags[FLAG_Z];
    assign flagV = flags[FLAG_V];

    always_comb begin
        cond = 1'b0;
        case (branchOp_e'(branch_op))
            BNEQ:    cond = !flagZ;
            BEQ:     cond = flagZ;
            BGT:     cond = !flagZ && !flagN;
            BLT:     cond = flagN;
            BGTE:    cond = !flagN;
            BLTE:    cond = flagN || flagZ;
            BOVFL:   cond = flagV;
            BUNCOND: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: branch/jump resolution plus a single-outstanding data-memory
// access FSM. Define MEM_TIMEOUT_EN to add the WAIT-state watchdog.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        flags,
    input  logic [2:0]        branch_op,
    input  logic              saw_br,
    input  logic              saw_j,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              pc_src,
    output logic              stall,
    output logic              mem_err,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ready,
    input  logic [DATA_W-1:0] dm_rdata
);

    memState_e state;
    memState_e nextState;
    logic      cond;
    logic      oneReq;
    logic      badReq;
    logic      accept;
    logic      complete;
    logic      expired;
    logic      timeout;

    branch_resolve uBranch (
        .flags     (flags),
        .branch_op (branch_op),
        .cond      (cond)
    );

    assign pc_src = (saw_br && cond) || saw_j;

    assign oneReq = mem_rd ^ mem_wr;
    assign badReq = mem_rd && mem_wr;

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        complete  = 1'b0;
        expired   = 1'b0;
        case (state)
            IDLE: begin
                if (oneReq) begin
                    accept    = 1'b1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                // a ready arriving with the timeout still counts as success
                if (dm_ready) begin
                    complete  = 1'b1;
                    nextState = DONE;
                end else if (timeout) begin
                    expired   = 1'b1;
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // stall is gated by rst because state is already IDLE while rst is high
    assign stall = !rst && ((state == IDLE && oneReq) || state == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            mem_err  <= 1'b0;
            if (accept) begin
                dm_req   <= 1'b1;
                dm_we    <= mem_wr;
                dm_addr  <= mem_addr;
                dm_wdata <= wr_data;
            end
            if (state == IDLE && badReq) begin
                mem_err <= 1'b1;
            end
            if (complete) begin
                dm_req <= 1'b0;
                if (!dm_we) begin
                    rd_data  <= dm_rdata;
                    rd_valid <= 1'b1;
                end
            end
            if (expired) begin
                dm_req  <= 1'b0;
                mem_err <= 1'b1;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] waitCnt;

    // waitCnt holds the number of WAIT cycles already elapsed
    assign timeout = (state == WAIT) && (waitCnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt <= '0;
        end else if (accept) begin
            waitCnt <= '0;
        end else if (state == WAIT && !dm_ready) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: branch resolution, load/store
// handshakes, illegal requests, mid-access reset and (optionally) timeout.
module tb_mem_stage;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] wr_data;
    logic          mem_rd;
    logic          mem_wr;
    logic [2:0]    flags;
    logic [2:0]    branch_op;
    logic          saw_br;
    logic          saw_j;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          pc_src;
    logic          stall;
    logic          mem_err;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ready;
    logic [DW-1:0] dm_rdata;

    int nChecks = 0;
    int nFails  = 0;

    mem_stage #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .wr_data   (wr_data),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .flags     (flags),
        .branch_op (branch_op),
        .saw_br    (saw_br),
        .saw_j     (saw_j),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .pc_src    (pc_src),
        .stall     (stall),
        .mem_err   (mem_err),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ready  (dm_ready),
        .dm_rdata  (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // settle combinational outputs after driving inputs
    task automatic settle();
        #1;
    endtask

    logic [7:0] expZ;
    logic [7:0] expNV;
    logic [7:0] expNone;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst = 1'b1; mem_addr = '0; wr_data = '0; mem_rd = 1'b0; mem_wr = 1'b0;
        flags = 3'b000; branch_op = 3'd0; saw_br = 1'b0; saw_j = 1'b0;
        dm_ready = 1'b0; dm_rdata = '0;

        // reset state, stall forced low, pc_src still live
        tick(); tick();
        mem_rd = 1'b1; saw_j = 1'b1;
        settle();
        checkVal("rst_dm_req", dm_req, 0);
        checkVal("rst_rd_data", rd_data, 0);
        checkVal("rst_rd_valid", rd_valid, 0);
        checkVal("rst_mem_err", mem_err, 0);
        checkVal("rst_stall", stall, 0);
        checkVal("rst_pc_src", pc_src, 1);
        mem_rd = 1'b0; saw_j = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // branch table: bit i is the expected cond for branch_op i
        expZ    = 8'b1011_0010;  // flags N=0 Z=1 V=0
        expNV   = 8'b1110_1001;  // flags N=1 Z=0 V=1
        expNone = 8'b1001_0101;  // flags all clear
        saw_br = 1'b1;
        for (int op = 0; op < 8; op++) begin
            branch_op = 3'(op);
            flags = 3'b010; settle();
            checkVal($sformatf("br_z_op%0d", op), pc_src, expZ[op]);
            flags = 3'b101; settle();
            checkVal($sformatf("br_nv_op%0d", op), pc_src, expNV[op]);
            flags = 3'b000; settle();
            checkVal($sformatf("br_none_op%0d", op), pc_src, expNone[op]);
        end
        saw_br = 1'b0; branch_op = 3'd7; settle();
        checkVal("no_br_uncond", pc_src, 0);
        saw_j = 1'b1; flags = 3'b010; branch_op = 3'd0; settle();
        checkVal("jump", pc_src, 1);
        saw_j = 1'b0;

        // load with immediate ready
        tick();
        mem_rd = 1'b1; mem_addr = 16'h0040; settle();
        checkVal("ld_c0_stall", stall, 1);
        checkVal("ld_c0_dm_req", dm_req, 0);
        tick();
        mem_rd = 1'b0; dm_ready = 1'b1; dm_rdata = 16'hBEEF; settle();
        checkVal("ld_c1_dm_req", dm_req, 1);
        checkVal("ld_c1_dm_we", dm_we, 0);
        checkVal("ld_c1_dm_addr", dm_addr, 16'h0040);
        checkVal("ld_c1_stall", stall, 1);
        checkVal("ld_c1_rd_valid", rd_valid, 0);
        tick();
        dm_ready = 1'b0; mem_rd = 1'b1; mem_addr = 16'h0099; settle();
        checkVal("ld_c2_rd_valid", rd_valid, 1);
        checkVal("ld_c2_rd_data", rd_data, 16'hBEEF);
        checkVal("ld_c2_stall", stall, 0);
        checkVal("ld_c2_dm_req", dm_req, 0);
        tick();
        mem_rd = 1'b0; settle();
        checkVal("ld_c3_rd_valid", rd_valid, 0);
        checkVal("ld_c3_dm_req_ignored", dm_req, 0);

        // store with three WAIT cycles
        tick();
        mem_wr = 1'b1; wr_data = 16'h1234; mem_addr = 16'h0080; settle();
        checkVal("st_c0_stall", stall, 1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            mem_wr = 1'b0;
            mem_rd = (c == 1);
            mem_addr = 16'h0F0F;
            dm_ready = (c == 3);
            dm_rdata = 16'hDEAD;
            settle();
            checkVal($sformatf("st_c%0d_dm_req", c), dm_req, 1);
            checkVal($sformatf("st_c%0d_dm_we", c), dm_we, 1);
            checkVal($sformatf("st_c%0d_dm_wdata", c), dm_wdata, 16'h1234);
            checkVal($sformatf("st_c%0d_dm_addr", c), dm_addr, 16'h0080);
            checkVal($sformatf("st_c%0d_stall", c), stall, 1);
            checkVal($sformatf("st_c%0d_rd_valid", c), rd_valid, 0);
        end
        tick();
        mem_rd = 1'b0; dm_ready = 1'b1; dm_rdata = 16'h5555; settle();
        checkVal("st_done_rd_valid", rd_valid, 0);
        checkVal("st_done_rd_data", rd_data, 16'hBEEF);
        checkVal("st_done_stall", stall, 0);
        checkVal("st_done_dm_req", dm_req, 0);
        tick();
        dm_ready = 1'b0; settle();
        checkVal("st_idle_rd_data", rd_data, 16'hBEEF);
        checkVal("st_idle_rd_valid", rd_valid, 0);

        // illegal simultaneous read and write
        tick();
        mem_rd = 1'b1; mem_wr = 1'b1; settle();
        checkVal("ill_c0_stall", stall, 0);
        checkVal("ill_c0_mem_err", mem_err, 0);
        tick();
        mem_rd = 1'b0; mem_wr = 1'b0; settle();
        checkVal("ill_c1_mem_err", mem_err, 1);
        checkVal("ill_c1_dm_req", dm_req, 0);
        checkVal("ill_c1_stall", stall, 0);
        tick();
        checkVal("ill_c2_mem_err", mem_err, 0);
        checkVal("ill_c2_dm_req", dm_req, 0);

        // reset in the middle of a read
        mem_rd = 1'b1; mem_addr = 16'h0044; settle();
        tick();
        mem_rd = 1'b0; settle();
        checkVal("rw_wait_dm_req", dm_req, 1);
        rst = 1'b1; settle();
        checkVal("rw_async_dm_req", dm_req, 0);
        checkVal("rw_async_stall", stall, 0);
        checkVal("rw_async_rd_data", rd_data, 0);
        tick();
        rst = 1'b0; dm_ready = 1'b1; dm_rdata = 16'h7777;
        tick();
        checkVal("rw_post_rd_valid", rd_valid, 0);
        checkVal("rw_post_dm_req", dm_req, 0);
        checkVal("rw_post_mem_err", mem_err, 0);
        checkVal("rw_post_rd_data", rd_data, 0);
        dm_ready = 1'b0;
        mem_wr = 1'b1; wr_data = 16'hA5A5; mem_addr = 16'h0010; settle();
        checkVal("rw_idle_stall", stall, 1);
        tick();
        mem_wr = 1'b0; dm_ready = 1'b1; settle();
        checkVal("rw_new_dm_req", dm_req, 1);
        checkVal("rw_new_dm_wdata", dm_wdata, 16'hA5A5);
        tick();
        dm_ready = 1'b0;
        tick();

`ifdef MEM_TIMEOUT_EN
        // preload rd_data, then let a read time out after four WAIT cycles
        mem_rd = 1'b1; mem_addr = 16'h0020; settle();
        tick();
        mem_rd = 1'b0; dm_ready = 1'b1; dm_rdata = 16'h5A5A;
        tick();
        dm_ready = 1'b0; settle();
        checkVal("to_pre_rd_data", rd_data, 16'h5A5A);
        tick();
        mem_rd = 1'b1; mem_addr = 16'h0030; settle();
        tick();
        mem_rd = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            settle();
            checkVal($sformatf("to_w%0d_dm_req", c), dm_req, 1);
            checkVal($sformatf("to_w%0d_mem_err", c), mem_err, 0);
            tick();
        end
        settle();
        checkVal("to_dm_req", dm_req, 0);
        checkVal("to_mem_err", mem_err, 1);
        checkVal("to_rd_valid", rd_valid, 0);
        checkVal("to_stall", stall, 0);
        tick();
        checkVal("to_after_mem_err", mem_err, 0);
        checkVal("to_after_rd_data", rd_data, 16'h5A5A);
        mem_wr = 1'b1; settle();
        checkVal("to_after_idle_stall", stall, 1);
        mem_wr = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
